// File: rtl/controlador_mac_if.sv
// Bus bundle for controlador_mac: sample/coefficient inputs, shared multiplier
// operands and product, and result/status outputs.
interface controlador_mac_if #(
  parameter int LARGO  = 24,
  parameter int ADDR_W = 2
);
  logic              sample_valid;
  logic [LARGO:0]    x_in;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [LARGO:0]    coef_data;
  logic [LARGO:0]    mult_a;
  logic [LARGO:0]    mult_b;
  logic [LARGO:0]    mult_y;
  logic              mult_ovf;
  logic [LARGO:0]    y_out;
  logic              y_valid;
  logic              busy;
  logic              ovf_flag;
  logic              sample_drop;

  modport master (
    output sample_valid, x_in, coef_we, coef_addr, coef_data, mult_y, mult_ovf,
    input  mult_a, mult_b, y_out, y_valid, busy, ovf_flag, sample_drop
  );

  modport slave (
    input  sample_valid, x_in, coef_we, coef_addr, coef_data, mult_y, mult_ovf,
    output mult_a, mult_b, y_out, y_valid, busy, ovf_flag, sample_drop
  );
endinterface

// File: rtl/controlador_mac.sv
// Sequential FIR MAC controller driving one shared external saturating multiplier.
// Define CONTROLADOR_MAC_SAT_EN for a saturating accumulator; otherwise it wraps.
module controlador_mac #(
  parameter int LARGO  = 24,
  parameter int MAG    = 8,
  parameter int PRES   = 16,
  parameter int ADDR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  controlador_mac_if.slave bus
);
  localparam int TAPS = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [LARGO:0]    acc_reg, acc_next, sum;
  logic [LARGO:0]    y_out_reg;
  logic [LARGO:0]    d_reg [TAPS];
  logic [LARGO:0]    c_reg [TAPS];
  logic              ovf_flag_reg, sample_drop_reg, ovf_set;
  logic              accept, coef_wr, last_tap, in_mac;

  // Sign bit + integer + fraction bits must exactly fill the data word.
  if (MAG + PRES != LARGO) begin : g_bad_format
    $error("controlador_mac: MAG + PRES must equal LARGO");
  end

  assign in_mac   = (state_reg == MAC);
  assign accept   = (state_reg == IDLE) && bus.sample_valid;
  assign coef_wr  = (state_reg == IDLE) && bus.coef_we;
  assign last_tap = (idx_reg == ADDR_W'(TAPS - 1));
  assign sum      = acc_reg + bus.mult_y;

`ifdef CONTROLADOR_MAC_SAT_EN
  localparam logic [LARGO:0] SAT_MAX = {1'b0, {LARGO{1'b1}}};
  localparam logic [LARGO:0] SAT_MIN = {1'b1, {LARGO{1'b0}}};
  logic acc_ovf;

  // Same-sign operands giving an opposite-sign result means the add overflowed.
  assign acc_ovf  = (acc_reg[LARGO] == bus.mult_y[LARGO]) && (sum[LARGO] != acc_reg[LARGO]);
  assign acc_next = acc_ovf ? (acc_reg[LARGO] ? SAT_MIN : SAT_MAX) : sum;
  assign ovf_set  = in_mac && (bus.mult_ovf || acc_ovf);
`else
  assign acc_next = sum;
  assign ovf_set  = in_mac && bus.mult_ovf;
`endif

  always_comb begin
    state_next  = state_reg;
    bus.mult_a  = '0;
    bus.mult_b  = '0;
    bus.y_valid = 1'b0;
    bus.busy    = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (bus.sample_valid) state_next = MAC;
      MAC: begin
        bus.mult_a = d_reg[idx_reg];
        bus.mult_b = c_reg[idx_reg];
        if (last_tap) state_next = DONE;
      end
      DONE: begin
        bus.y_valid = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      acc_reg         <= '0;
      y_out_reg       <= '0;
      ovf_flag_reg    <= 1'b0;
      sample_drop_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sample_drop_reg <= bus.sample_valid && (state_reg != IDLE);
      if (ovf_set) ovf_flag_reg <= 1'b1;
      if (accept) begin
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (in_mac) begin
        acc_reg <= acc_next;
        idx_reg <= idx_reg + 1'b1;
        // Result is published as DONE is entered so it is valid alongside y_valid.
        if (last_tap) y_out_reg <= acc_next;
      end
    end
  end

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       d_reg[gi] <= '0;
        else if (accept) d_reg[gi] <= bus.x_in;
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       d_reg[gi] <= '0;
        else if (accept) d_reg[gi] <= d_reg[gi-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        c_reg[gi] <= '0;
      else if (coef_wr && (bus.coef_addr == ADDR_W'(gi)))
        c_reg[gi] <= bus.coef_data;
    end
  end

  assign bus.y_out       = y_out_reg;
  assign bus.ovf_flag    = ovf_flag_reg;
  assign bus.sample_drop = sample_drop_reg;
endmodule

// File: tb/tb_controlador_mac.sv
// Scoreboard bench for controlador_mac: stimulus pushes expected results,
// a negedge monitor pops and compares on every y_valid.
module tb_controlador_mac;
  localparam int LARGO = 24;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [LARGO:0] exp_q [$];
  longint prod;

  controlador_mac_if #(.LARGO(LARGO), .ADDR_W(ADDR_W)) bus ();

  controlador_mac #(.LARGO(LARGO), .MAG(8), .PRES(16), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External Q8.16 saturating multiplier model.
  always_comb begin
    prod = longint'($signed(bus.mult_a)) * longint'($signed(bus.mult_b));
    prod = prod >>> 16;
    bus.mult_ovf = 1'b0;
    bus.mult_y   = prod[LARGO:0];
    if (prod > 64'sh0FFFFFF) begin
      bus.mult_y   = 25'h0FFFFFF;
      bus.mult_ovf = 1'b1;
    end else if (prod < -64'sh1000000) begin
      bus.mult_y   = 25'h1000000;
      bus.mult_ovf = 1'b1;
    end
  end

  // Monitor: every result strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.y_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_y_valid y_out=%h with no expected result", bus.y_out);
      end else begin
        logic [LARGO:0] e;
        e = exp_q.pop_front();
        if (bus.y_out !== e) begin
          failures++;
          $display("FAIL y_out got=%h exp=%h", bus.y_out, e);
        end else
          $display("result y_out=%h ok", bus.y_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run(input logic [LARGO:0] x, input logic [LARGO:0] e);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = x;
    exp_q.push_back(e);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    wait_idle();
    $display("sample x=%h expect=%h", x, e);
  endtask

  task automatic wr_coef(input logic [ADDR_W-1:0] a, input logic [LARGO:0] v);
    @(negedge clk);
    bus.coef_we = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = v;
    @(negedge clk);
    bus.coef_we = 1'b0;
    $display("coef c[%0d]=%h", a, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.x_in = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_y_out", 32'(bus.y_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
    chk("rst_ovf_flag", 32'(bus.ovf_flag), 32'h0);
    chk("rst_sample_drop", 32'(bus.sample_drop), 32'h0);
    chk("rst_mult_a", 32'(bus.mult_a), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) wr_coef(ADDR_W'(i), 25'h010000);

    // Impulse with cycle-exact latency on the first sample.
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = 25'h010000;
    exp_q.push_back(25'h010000);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      chk($sformatf("lat_busy_c%0d", cyc), 32'(bus.busy), (cyc <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("lat_yvalid_c%0d", cyc), 32'(bus.y_valid), (cyc == 5) ? 32'd1 : 32'd0);
    end
    chk("idle_mult_b", 32'(bus.mult_b), 32'h0);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h000000);

    // Sample while busy is dropped and leaves the delay line alone.
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = 25'h020000;
    exp_q.push_back(25'h020000);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = 25'h030000;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("drop_pulse", 32'(bus.sample_drop), 32'd1);
    @(negedge clk);
    chk("drop_end", 32'(bus.sample_drop), 32'd0);
    wait_idle();
    run(25'h0, 25'h020000);
    run(25'h0, 25'h020000);
    run(25'h0, 25'h020000);
    run(25'h0, 25'h000000);

    // Coefficient write while busy is ignored.
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = 25'h010000;
    exp_q.push_back(25'h010000);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    bus.coef_we = 1'b1;
    bus.coef_addr = '0;
    bus.coef_data = 25'h020000;
    @(negedge clk);
    bus.coef_we = 1'b0;
    wait_idle();
    run(25'h010000, 25'h020000);
    run(25'h0, 25'h020000);
    run(25'h0, 25'h020000);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h000000);

    // Coefficient write and sample in the same idle cycle.
    @(negedge clk);
    bus.coef_we = 1'b1;
    bus.coef_addr = '0;
    bus.coef_data = 25'h020000;
    bus.sample_valid = 1'b1;
    bus.x_in = 25'h010000;
    exp_q.push_back(25'h020000);
    @(negedge clk);
    bus.coef_we = 1'b0;
    bus.sample_valid = 1'b0;
    wait_idle();
    wr_coef(2'd0, 25'h010000);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h010000);
    run(25'h0, 25'h000000);

    // Accumulator overflow: 4 x 64.0 exceeds the format.
    for (int i = 0; i < 4; i++) wr_coef(ADDR_W'(i), 25'h400000);
    run(25'h010000, 25'h400000);
    run(25'h010000, 25'h800000);
    run(25'h010000, 25'hC00000);
`ifdef CONTROLADOR_MAC_SAT_EN
    run(25'h010000, 25'h0FFFFFF);
    chk("acc_ovf_flag", 32'(bus.ovf_flag), 32'd1);
`else
    run(25'h010000, 25'h1000000);
    chk("acc_ovf_flag", 32'(bus.ovf_flag), 32'd0);
`endif

    // Multiplier overflow: 4.0 * 64.0 saturates in the multiplier.
`ifdef CONTROLADOR_MAC_SAT_EN
    run(25'h040000, 25'h0FFFFFF);
`else
    run(25'h040000, 25'h1BFFFFF);
`endif
    chk("mult_ovf_flag", 32'(bus.ovf_flag), 32'd1);

    // Reset at idx 2 aborts the computation and clears coefficients.
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = '0;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_y_out", 32'(bus.y_out), 32'h0);
    chk("abort_ovf_flag", 32'(bus.ovf_flag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(25'h010000, 25'h000000);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/controlador_mac.md
CONTROLADOR_MAC -- requirements
Module: controlador_mac

Interface
REQ-001 SHALL have parameter LARGO, default 24, MSB index; all data words are LARGO+1 bits, signed two's complement.
REQ-002 SHALL have parameter MAG, default 8, integer bits of the fixed-point format.
REQ-003 SHALL have parameter PRES, default 16, fraction bits of the fixed-point format (1.0 = 0x010000).
REQ-004 SHALL have parameter ADDR_W, default 2; tap count TAPS = 2^ADDR_W.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port sample_valid, input, 1, one-cycle strobe qualifying x_in.
REQ-008 SHALL have port x_in, input, LARGO+1, new input sample.
REQ-009 SHALL have ports coef_we (input, 1), coef_addr (input, ADDR_W) and coef_data (input, LARGO+1), the coefficient write port.
REQ-010 SHALL have ports mult_a and mult_b, outputs, LARGO+1 each, operands driven to the shared external saturating multiplier.
REQ-011 SHALL have ports mult_y (input, LARGO+1, product) and mult_ovf (input, 1, multiplier overflow flag).
REQ-012 SHALL have port y_out, output, LARGO+1, filter result, held until the next result.
REQ-013 SHALL have ports y_valid (output, 1, one-cycle result strobe) and busy (output, 1, high when state != IDLE).
REQ-014 SHALL have ports ovf_flag (output, 1, sticky overflow) and sample_drop (output, 1, one-cycle pulse for a rejected sample).

Function
REQ-015 SHALL implement FSM states IDLE, MAC and DONE.
REQ-016 IDLE + sample_valid: SHALL shift the delay line (d[0]=x_in, d[k]=d[k-1]), clear acc and idx, and go to MAC.
REQ-017 MAC: SHALL drive mult_a=d[idx] and mult_b=c[idx] combinationally, register acc=acc+mult_y, and increment idx; idx==TAPS-1 SHALL go to DONE.
REQ-018 DONE: SHALL assert y_valid for exactly one cycle, load y_out=acc, and return to IDLE.
REQ-019 Latency SHALL be fixed: sample_valid accepted at edge 0 gives y_valid high in the cycle after edge TAPS, and busy is high for TAPS+1 cycles.
REQ-020 mult_a and mult_b SHALL be 0 outside MAC.
REQ-021 sample_valid while busy SHALL be ignored (delay line and result unaffected), and sample_drop SHALL pulse on the following cycle.
REQ-022 coef_we in IDLE SHALL write c[coef_addr]=coef_data; coef_we while busy SHALL be ignored.
REQ-023 coef_we and sample_valid in the same IDLE cycle SHALL both take effect; the new coefficient SHALL be used by that computation.
REQ-024 mult_ovf sampled high in any MAC cycle SHALL set ovf_flag, which stays high until reset.
REQ-025 An accumulator overflow SHALL be detected from the operand and result sign bits, in the same way as the multiplier.

Reset
REQ-026 Reset SHALL force state IDLE, idx=0, acc=0, the delay line and all coefficients to 0, y_out=0, and y_valid, busy, ovf_flag and sample_drop to 0.
REQ-027 Reset asserted mid-MAC SHALL abort the computation with no y_valid; operation resumes from IDLE on the first edge after release.

Configuration
REQ-028 Macro CONTROLADOR_MAC_SAT_EN defined: acc+mult_y SHALL clip to 0x0FFFFFF (positive) or 0x1000000 (negative) on overflow and SHALL set ovf_flag.
REQ-029 Macro CONTROLADOR_MAC_SAT_EN undefined: the accumulator SHALL wrap modulo 2^(LARGO+1), and ovf_flag SHALL be set only by mult_ovf.

Verification
REQ-030 Impulse: c[0..3]=0x010000; x=0x010000 then 0,0,0,0 -> y_out=0x010000 for 4 results, then 0x000000.
REQ-031 Latency: sample_valid at edge 0, TAPS=4 -> busy high cycles 1..5, y_valid high only in cycle 5.
REQ-032 Saturation (SAT_EN): c[all]=0x400000 (64.0); x=0x010000 on four samples -> 4th y_out=0x0FFFFFF and ovf_flag=1; without SAT_EN the result wraps and ovf_flag=0.
REQ-033 Busy drop: sample_valid 2 cycles after an accepted sample -> sample_drop pulse, y_out equals the single-sample result, delay line unchanged.
REQ-034 Reset at MAC idx=2 -> busy=0 immediately, no y_valid, coefficients read back as 0 (impulse test yields 0).
REQ-035 Coefficient write while busy: coef_we at cycle 2 with coef_addr=0, coef_data=0x020000 -> c[0] unchanged, and the next result uses the old value.
